// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter that drives the select of an N-input mux and holds the
// grant stable until the downstream consumer accepts the transfer.
module rr_mux_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  output logic [SELW-1:0] sel_out,
  output logic [N-1:0]    grant_out,
  output logic            out_valid,
  input  logic            out_ready
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e          state_q, state_d;
  logic [SELW-1:0] ptr_q, ptr_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [N-1:0]    grant_q, grant_d;

  // Requests rotated so that bit 0 is the current highest-priority requester.
  logic [2*N-1:0]  req_dbl;
  logic [SELW-1:0] pick_off;
  logic            pick_found;
  logic [SELW:0]   pick_sum;
  logic [SELW-1:0] pick_idx;
  logic            xfer;

  assign req_dbl = {in_valid, in_valid} >> ptr_q;

  always_comb begin
    pick_found = 1'b0;
    pick_off   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!pick_found && req_dbl[i]) begin
        pick_found = 1'b1;
        pick_off   = SELW'(i);
      end
    end
  end

  // Undo the rotation; the sum never reaches 2N, so one conditional subtract
  // suffices and handles non-power-of-two N.
  always_comb begin
    pick_sum = {1'b0, ptr_q} + {1'b0, pick_off};
    if (pick_sum >= (SELW+1)'(N)) begin
      pick_sum = pick_sum - (SELW+1)'(N);
    end
    pick_idx = pick_sum[SELW-1:0];
  end

  assign xfer = (state_q == StBusy) && out_ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          state_d = StBusy;
          sel_d   = pick_idx;
          grant_d = {{(N-1){1'b0}}, 1'b1} << pick_idx;
        end
      end
      StBusy: begin
        if (xfer) begin
          state_d = StIdle;
          grant_d = '0;
          ptr_d   = (sel_q == SELW'(N-1)) ? '0 : sel_q + SELW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      sel_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
    end
  end

  assign sel_out   = sel_q;
  assign grant_out = grant_q;
  assign out_valid = (state_q == StBusy);
  // Reset suppresses the pop so an interrupted item is re-arbitrated later.
  assign in_ready  = (xfer && !rst) ? grant_q : '0;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter with N=4 and a 4-bit data mux model.
module tb_rr_mux_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned SELW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [SELW-1:0] sel_out;
  logic [N-1:0]    grant_out;
  logic            out_valid;
  logic            out_ready;
  logic [3:0]      mux_out;

  int total = 0;
  int bad   = 0;

  rr_mux_arbiter #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel_out   (sel_out),
    .grant_out (grant_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Mux with data_in = {9,5,3,2}: input 0 carries 2, input 3 carries 9.
  always_comb begin
    case (sel_out)
      2'd0:    mux_out = 4'd2;
      2'd1:    mux_out = 4'd3;
      2'd2:    mux_out = 4'd5;
      2'd3:    mux_out = 4'd9;
      default: mux_out = 4'hx;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_busy(input string tag, input int g, input logic [3:0] dat,
                          input logic [3:0] rdy);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_sel"}, 32'(sel_out), 32'(g));
    chk({tag, "_grant"}, 32'(grant_out), 32'(4'b0001 << g));
    chk({tag, "_data"}, 32'(mux_out), 32'(dat));
    chk({tag, "_ready"}, 32'(in_ready), 32'(rdy));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_grant"}, 32'(grant_out), 32'd0);
    chk({tag, "_ready"}, 32'(in_ready), 32'd0);
  endtask

  initial begin
    // Reset held two cycles with all requesters active.
    rst       = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk_idle("reset");
      chk("reset_sel", 32'(sel_out), 32'd0);
    end

    // Round-robin from ptr=0 with all requesters held.
    rst = 1'b0;
    tick();
    chk_busy("rr0", 0, 4'd2, 4'b0001);
    tick();
    chk_idle("rr0_bubble");
    tick();
    chk_busy("rr1", 1, 4'd3, 4'b0010);
    tick();
    chk_idle("rr1_bubble");
    tick();
    chk_busy("rr2", 2, 4'd5, 4'b0100);
    tick();
    chk_idle("rr2_bubble");
    tick();
    chk_busy("rr3", 3, 4'd9, 4'b1000);
    tick();
    chk_idle("rr3_bubble");
    tick();
    chk_busy("rr4", 0, 4'd2, 4'b0001);
    in_valid = 4'b0000;
    tick();
    chk_idle("rr4_bubble");

    // Single request on requester 2; ptr is 1 here.
    in_valid = 4'b0100;
    tick();
    chk_busy("single", 2, 4'd5, 4'b0100);
    in_valid = 4'b0000;
    tick();
    chk_idle("single_after");

    // Wrap: serve requester 3, then 0 must beat 3.
    in_valid = 4'b1000;
    tick();
    chk_busy("wrap_g3", 3, 4'd9, 4'b1000);
    in_valid = 4'b1001;
    tick();
    chk_idle("wrap_bubble");
    tick();
    chk_busy("wrap_g0", 0, 4'd2, 4'b0001);
    in_valid = 4'b0000;
    tick();
    chk_idle("wrap_after");

    // Backpressure on grant 1, with requester 0 rising during the stall.
    in_valid  = 4'b0010;
    out_ready = 1'b0;
    tick();
    chk_busy("bp_start", 1, 4'd3, 4'b0000);
    in_valid = 4'b0011;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_busy("bp_stall", 1, 4'd3, 4'b0000);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'b0010);
    in_valid = 4'b0001;
    tick();
    chk_idle("bp_bubble");
    tick();
    chk_busy("bp_next", 0, 4'd2, 4'b0001);
    in_valid = 4'b0000;
    tick();
    chk_idle("bp_after");

    // Reset in the same cycle as an accepted transfer on grant 2.
    in_valid = 4'b0100;
    tick();
    chk_busy("rstb_g2", 2, 4'd5, 4'b0100);
    rst = 1'b1;
    #1;
    chk("rstb_ready", 32'(in_ready), 32'd0);
    tick();
    chk_idle("rstb_after");
    chk("rstb_sel", 32'(sel_out), 32'd0);
    rst      = 1'b0;
    in_valid = 4'b1111;
    tick();
    chk_busy("rstb_ptr0", 0, 4'd2, 4'b0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Round-robin arbiter that generates the select for a parameterized N-input `mux`. It picks one of N valid/ready requesters, drives the mux select and a one-hot grant, and holds both stable until the downstream consumer accepts the transfer. The mux carries the data path: requester data buses feed the mux `data_in`, and downstream takes mux `data_out` qualified by `out_valid`.

## Interface
- `N`, default 4: number of requesters; N ≥ 2, need not be a power of two.
- `SELW`, localparam `$clog2(N)`: select width, which matches the mux `sel_in` width.
- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `rst`, input, 1: reset. Synchronous and active-high.
- `in_valid`, input, N: per-requester request; bit i belongs to requester i.
- `in_ready`, output, N: per-requester pop; bit i high means requester i's item is consumed this cycle.
- `sel_out`, output, SELW: mux select. Connects directly to mux `sel_in`.
- `grant_out`, output, N: one-hot copy of the current grant; all zeros when idle.
- `out_valid`, output, 1: mux `data_out` holds a valid item.
- `out_ready`, input, 1: downstream accepts the item when `out_valid` is also high.

## Operation
- Two states, IDLE and BUSY, plus a priority pointer `ptr` in the range 0..N-1.
- IDLE behaviour:
  - If any `in_valid` bit is set, scan indices ptr, ptr+1, … N-1, 0, … ptr-1.
  - The first index with `in_valid` set becomes the grant g.
  - Next cycle: state BUSY, `sel_out`=g, `grant_out`=1<<g.
  - If no bit is set, stay in IDLE.
- BUSY behaviour:
  - `out_valid`=1.
  - `in_ready` = `grant_out` when `out_ready`=1, otherwise 0. This output is combinational from state, `grant_out` and `out_ready`.
  - A transfer happens in a cycle where `out_valid` and `out_ready` are both 1. On a transfer: next state IDLE; `ptr` <= (g==N-1) ? 0 : g+1; `grant_out` <= 0. `sel_out` keeps its last value.
  - Without `out_ready`, state, grant, select and `ptr` hold.
  - Changes on other `in_valid` bits are ignored while in BUSY.
- Requester contract: `in_valid` stays high with stable data until `in_ready`.
  - A requester that drops `in_valid` while granted is not checked.
  - The arbiter still completes that transfer when `out_ready` arrives.
- Fairness: a requester that has just been served gets lowest priority on the next arbitration. Any continuously asserted requester is granted within N arbitrations.
- `in_ready` is never high for more than one bit and is never high outside BUSY.

## Timing
- Reset values: state IDLE, `ptr`=0, `sel_out`=0, `grant_out`=0, `out_valid`=0, `in_ready`=0.
- Reset wins over everything. In any cycle where `rst`=1, `in_ready` is forced to 0, including mid-BUSY with `out_ready`=1. The pending item is not popped and is re-arbitrated after reset.
- Latency:
  - `in_valid` high in IDLE at cycle t gives `out_valid`=1 and a valid `sel_out` at cycle t+1.
  - With `out_ready`=1 at t+1, `in_ready` pulses at t+1 and `out_valid`=0 at t+2.
- Throughput: at most one transfer per 2 cycles. There is a mandatory IDLE bubble after every transfer.
- `sel_out`, `grant_out` and `out_valid` are registered. Mux output is valid in the same cycle as `out_valid`.
- `ptr` wraps from N-1 to 0 for every N, including non-power-of-two values.

## Test plan
Tests use N=4 and a mux with DATAW=4, N=4, `data_in`={9,5,3,2}.
- Reset: hold `rst`=1 for 2 cycles with `in_valid`=1111. Required: `out_valid`=0, `sel_out`=0, `grant_out`=0000, `in_ready`=0000 throughout.
- Single request: `in_valid`=0100, `out_ready`=1. Next cycle: `out_valid`=1, `sel_out`=2, `grant_out`=0100, mux out=5, `in_ready`=0100. The following cycle: `out_valid`=0.
- Round-robin: `in_valid`=1111 held, `out_ready`=1. Grants are 0,1,2,3,0 on every second cycle, with mux out 2,3,5,9,2.
- Backpressure: grant 1 active, `out_ready`=0 for 3 cycles, raise `in_valid[0]`.
  - During the stall: `sel_out` stays 1, `out_valid` stays 1, `in_ready`=0000.
  - Then `out_ready`=1: `in_ready`=0010. Next arbitration picks 2 if it is requesting, otherwise 3, otherwise 0.
- Wrap: after a transfer on grant 3, `in_valid`=1001. The next grant is 0 (`ptr` wrapped to 0), not 3.
- Reset mid-BUSY: grant 2 with `out_ready`=1 and `rst`=1 in the same cycle. Required: `in_ready`=0000; the next cycle has `out_valid`=0 and `ptr`=0.
